// File: rtl/instr_loader_if.sv
// Byte-stream input, CPU instruction-write output and status bundle for instr_loader.
interface instr_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        clr_err_i;
    logic        wr_instr_en_o;
    logic [31:0] wr_instr_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] word_cnt_o;

    modport master (
        output byte_valid_i, byte_i, clr_err_i,
        input  byte_ready_o, wr_instr_en_o, wr_instr_o, cpu_hold_o,
               busy_o, done_o, err_o, word_cnt_o
    );

    modport slave (
        input  byte_valid_i, byte_i, clr_err_i,
        output byte_ready_o, wr_instr_en_o, wr_instr_o, cpu_hold_o,
               busy_o, done_o, err_o, word_cnt_o
    );
endinterface

// File: rtl/instr_loader.sv
// Frames a UART byte stream (SYNC, LEN, data words, CSUM) into 32-bit CPU
// instruction writes, holding the CPU in reset while a load is in progress.
module instr_loader #(
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    instr_loader_if.slave lb
);

    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   asm_q, asm_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          ready_q, ready_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_instr_q, wr_instr_d;
    logic          hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          accept;
    logic [15:0]   len_full;
    logic [15:0]   cnt_inc;

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            timer_q    <= '0;
            ready_q    <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_instr_q <= '0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            timer_q    <= timer_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            wr_instr_q <= wr_instr_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign accept   = lb.byte_valid_i & ready_q;
    assign len_full = {lb.byte_i, len_q[7:0]};
    assign cnt_inc  = cnt_q + 16'd1;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        timer_d    = timer_q;
        wr_en_d    = 1'b0;
        wr_instr_d = wr_instr_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (accept && (lb.byte_i == SYNC_BYTE)) begin
                    state_d = S_LEN_LO;
                    cnt_d   = '0;
                    csum_d  = '0;
                    idx_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = lb.byte_i;
                    csum_d     = csum_q ^ lb.byte_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = len_full;
                    csum_d  = csum_q ^ lb.byte_i;
                    state_d = ((len_full == 16'd0) || (len_full > MAX_W)) ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ lb.byte_i;
                    asm_d  = {lb.byte_i, asm_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wr_instr_d = {lb.byte_i, asm_q[31:8]};
                        wr_en_d    = 1'b1;
                        cnt_d      = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (lb.byte_i == csum_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                timer_d = '0;
                if (lb.clr_err_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout inside a frame; partial word is dropped with the frame
        if ((state_q != S_IDLE) && (state_q != S_ERR)) begin
            if (accept) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                state_d = S_ERR;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        ready_d = (state_d != S_ERR);
        hold_d  = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_ERR);
        err_d   = (state_d == S_ERR);
    end

    assign lb.byte_ready_o  = ready_q;
    assign lb.wr_instr_en_o = wr_en_q;
    assign lb.wr_instr_o    = wr_instr_q;
    assign lb.cpu_hold_o    = hold_q;
    assign lb.busy_o        = busy_q;
    assign lb.done_o        = done_q;
    assign lb.err_o         = err_q;
    assign lb.word_cnt_o    = cnt_q;

endmodule
